// File: rtl/drive_arbiter_if.sv
// Drive arbiter bus: sensor-side requests in, motor-side commands out.
// The sensor/stimulus side is the master, the arbiter is the slave.
interface drive_arbiter_if;
    logic       obs_stop;
    logic       man_en;
    logic [2:0] man_mode;
    logic       line_valid;
    logic [2:0] line_mode;
    logic [2:0] mode_out;
    logic [9:0] duty;
    logic [1:0] dir_left;
    logic [1:0] dir_right;
    logic [1:0] grant;
    logic       lost;

    modport master (
        output obs_stop,
        output man_en,
        output man_mode,
        output line_valid,
        output line_mode,
        input  mode_out,
        input  duty,
        input  dir_left,
        input  dir_right,
        input  grant,
        input  lost
    );

    modport slave (
        input  obs_stop,
        input  man_en,
        input  man_mode,
        input  line_valid,
        input  line_mode,
        output mode_out,
        output duty,
        output dir_left,
        output dir_right,
        output grant,
        output lost
    );
endinterface

// File: rtl/drive_arbiter.sv
// Drive-mode arbiter: obstacle > manual > line priority, mode-hold dwell,
// lost-line recovery timeout and soft-start PWM duty ramp.
module drive_arbiter #(
    parameter int HOLD_CYCLES  = 5_000_000,
    parameter int LOST_TIMEOUT = 100_000_000,
    parameter int RAMP_DIV     = 100_000,
    parameter int RAMP_STEP    = 8,
    parameter int DUTY_MAX     = 1023
) (
    input logic            clk,
    input logic            rst,
    drive_arbiter_if.slave bus
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int LW = $clog2(LOST_TIMEOUT + 1);
    localparam int DW = $clog2(RAMP_DIV + 1);

    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] LOST_LOAD = LW'(LOST_TIMEOUT - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(RAMP_DIV - 1);
    localparam logic [10:0]   STEP      = 11'(RAMP_STEP);
    localparam logic [10:0]   DMAX      = 11'(DUTY_MAX);

    localparam logic [2:0] M_HARD_L = 3'b000;
    localparam logic [2:0] M_HARD_R = 3'b001;
    localparam logic [2:0] M_TURN_L = 3'b100;
    localparam logic [2:0] M_TURN_R = 3'b101;
    localparam logic [2:0] M_STOP   = 3'b111;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_OBS  = 2'b01;
    localparam logic [1:0] G_LINE = 2'b10;
    localparam logic [1:0] G_MAN  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_LOST,
        S_HALT,
        S_BLOCKED
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [2:0]    mode_q;
    logic [2:0]    mode_d;
    logic [1:0]    grant_q;
    logic [1:0]    grant_d;
    logic          lost_q;
    logic          lost_d;
    logic [1:0]    dir_l_q;
    logic [1:0]    dir_r_q;
    logic [9:0]    duty_q;
    logic [9:0]    duty_d;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_d;
    logic [LW-1:0] lost_cnt;
    logic [LW-1:0] lcnt_d;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_d;
    logic [10:0]   duty_sum;

    logic          win_valid;
    logic [2:0]    win_mode;
    logic [1:0]    win_grant;
    logic [2:0]    man_code;
    logic [2:0]    line_code;

    // The only unassigned code (011) is treated as STOP.
    function automatic logic [2:0] clean(input logic [2:0] code);
        return (code == 3'b011) ? M_STOP : code;
    endfunction

    // Recovery turn used while the line is lost.
    function automatic logic [2:0] lost_map(input logic [2:0] code);
        logic [2:0] res;
        res = M_STOP;
        if (code == M_TURN_L || code == M_HARD_L) begin
            res = M_HARD_L;
        end else if (code == M_TURN_R || code == M_HARD_R) begin
            res = M_HARD_R;
        end
        return res;
    endfunction

    function automatic logic [1:0] dir_l(input logic [2:0] code);
        logic [1:0] res;
        res = 2'b01;
        if (code == M_STOP) begin
            res = 2'b00;
        end else if (code == M_HARD_L) begin
            res = 2'b10;
        end
        return res;
    endfunction

    function automatic logic [1:0] dir_r(input logic [2:0] code);
        logic [1:0] res;
        res = 2'b01;
        if (code == M_STOP) begin
            res = 2'b00;
        end else if (code == M_HARD_R) begin
            res = 2'b10;
        end
        return res;
    endfunction

    assign man_code  = clean(bus.man_mode);
    assign line_code = clean(bus.line_mode);

    // Pick the highest-priority non-obstacle requester.
    always_comb begin
        win_valid = 1'b0;
        win_mode  = M_STOP;
        win_grant = G_NONE;
        if (bus.man_en) begin
            win_valid = 1'b1;
            win_mode  = man_code;
            win_grant = G_MAN;
        end else if (bus.line_valid) begin
            win_valid = 1'b1;
            win_mode  = line_code;
            win_grant = G_LINE;
        end
    end

    // Next state, mode, grant and dwell/lost counters.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        grant_d = grant_q;
        hold_d  = '0;
        lcnt_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                mode_d  = M_STOP;
                grant_d = G_NONE;
                if (bus.obs_stop) begin
                    state_d = S_BLOCKED;
                    grant_d = G_OBS;
                end else if (win_valid) begin
                    state_d = S_RUN;
                    mode_d  = win_mode;
                    grant_d = win_grant;
                end
            end
            S_RUN: begin
                if (bus.obs_stop) begin
                    state_d = S_BLOCKED;
                    mode_d  = M_STOP;
                    grant_d = G_OBS;
                end else if (win_valid) begin
                    grant_d = win_grant;
                    if (win_mode != mode_q) begin
                        state_d = S_HOLD;
                        mode_d  = win_mode;
                        hold_d  = HOLD_LOAD;
                    end
                end else if (grant_q == G_LINE) begin
                    state_d = S_LOST;
                    mode_d  = lost_map(mode_q);
                    lcnt_d  = LOST_LOAD;
                end else begin
                    state_d = S_IDLE;
                    mode_d  = M_STOP;
                    grant_d = G_NONE;
                end
            end
            S_HOLD: begin
                if (bus.obs_stop) begin
                    state_d = S_BLOCKED;
                    mode_d  = M_STOP;
                    grant_d = G_OBS;
                end else if (bus.man_en && grant_q == G_LINE) begin
                    mode_d  = man_code;
                    grant_d = G_MAN;
                    hold_d  = HOLD_LOAD;
                end else if (hold_cnt == '0) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_cnt - 1'b1;
                end
            end
            S_LOST: begin
                if (bus.obs_stop) begin
                    state_d = S_BLOCKED;
                    mode_d  = M_STOP;
                    grant_d = G_OBS;
                end else if (win_valid) begin
                    state_d = S_RUN;
                    mode_d  = win_mode;
                    grant_d = win_grant;
                end else if (mode_q == M_STOP || lost_cnt == '0) begin
                    state_d = S_HALT;
                    mode_d  = M_STOP;
                    grant_d = G_NONE;
                end else begin
                    lcnt_d = lost_cnt - 1'b1;
                end
            end
            S_HALT: begin
                mode_d  = M_STOP;
                grant_d = G_NONE;
                if (bus.man_en || bus.line_valid) begin
                    state_d = S_IDLE;
                end
            end
            S_BLOCKED: begin
                mode_d  = M_STOP;
                grant_d = G_OBS;
                if (!bus.obs_stop) begin
                    state_d = S_IDLE;
                    grant_d = G_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                mode_d  = M_STOP;
                grant_d = G_NONE;
            end
        endcase
        lost_d = (state_d == S_LOST) || (state_d == S_HALT);
    end

    // Soft-start ramp; any STOP clears duty and divider on the same edge.
    always_comb begin
        duty_sum = {1'b0, duty_q} + STEP;
        duty_d   = duty_q;
        div_d    = div_cnt;
        if (mode_d == M_STOP) begin
            duty_d = '0;
            div_d  = '0;
        end else if (div_cnt == DIV_LAST) begin
            div_d  = '0;
            duty_d = (duty_sum > DMAX) ? DMAX[9:0] : duty_sum[9:0];
        end else begin
            div_d = div_cnt + 1'b1;
        end
    end

    // Register every output and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= M_STOP;
            grant_q  <= G_NONE;
            lost_q   <= 1'b0;
            dir_l_q  <= 2'b00;
            dir_r_q  <= 2'b00;
            duty_q   <= '0;
            hold_cnt <= '0;
            lost_cnt <= '0;
            div_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            grant_q  <= grant_d;
            lost_q   <= lost_d;
            dir_l_q  <= dir_l(mode_d);
            dir_r_q  <= dir_r(mode_d);
            duty_q   <= duty_d;
            hold_cnt <= hold_d;
            lost_cnt <= lcnt_d;
            div_cnt  <= div_d;
        end
    end

    assign bus.mode_out  = mode_q;
    assign bus.duty      = duty_q;
    assign bus.dir_left  = dir_l_q;
    assign bus.dir_right = dir_r_q;
    assign bus.grant     = grant_q;
    assign bus.lost      = lost_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// Bench for drive_arbiter: directed test-plan scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_drive_arbiter;

    localparam int H  = 4;
    localparam int LT = 20;
    localparam int RD = 2;
    localparam int RS = 256;
    localparam int DM = 1023;

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_HOLD = 2;
    localparam int P_LOST = 3;
    localparam int P_HALT = 4;
    localparam int P_BLK  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    drive_arbiter_if bus ();

    drive_arbiter #(
        .HOLD_CYCLES (H),
        .LOST_TIMEOUT(LT),
        .RAMP_DIV    (RD),
        .RAMP_STEP   (RS),
        .DUTY_MAX    (DM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit model_on = 1'b0;

    int ph      = P_IDLE;
    int m_mode  = 7;
    int m_grant = 0;
    int age     = 0;
    int nonstop = 0;

    int dl_tab [8] = '{2, 1, 1, 0, 1, 1, 1, 0};
    int dr_tab [8] = '{1, 2, 1, 0, 1, 1, 1, 0};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clean(input int c);
        return (c == 3) ? 7 : c;
    endfunction

    function automatic int lost_of(input int c);
        if (c == 4 || c == 0) return 0;
        if (c == 5 || c == 1) return 1;
        return 7;
    endfunction

    function automatic int exp_duty();
        int t;
        if (m_mode == 7) return 0;
        t = (nonstop / RD) * RS;
        return (t > DM) ? DM : t;
    endfunction

    function automatic void go(input int p, input int md, input int g);
        ph      = p;
        m_mode  = md;
        m_grant = g;
        age     = 0;
    endfunction

    bit obs_s, man_s, lin_s, wv;
    int mm, lm, wm, wg;

    // Behavioural model: advances once per rising edge from the sampled inputs.
    always @(posedge clk) begin
        obs_s = bus.obs_stop;
        man_s = bus.man_en;
        lin_s = bus.line_valid;
        mm    = clean(int'(bus.man_mode));
        lm    = clean(int'(bus.line_mode));
        wv    = man_s || lin_s;
        wm    = man_s ? mm : lm;
        wg    = man_s ? 3 : 2;
        if (rst) begin
            go(P_IDLE, 7, 0);
        end else begin
            age++;
            case (ph)
                P_IDLE: begin
                    if (obs_s) go(P_BLK, 7, 1);
                    else if (wv) go(P_RUN, wm, wg);
                end
                P_RUN: begin
                    if (obs_s) go(P_BLK, 7, 1);
                    else if (wv) begin
                        if (wm != m_mode) go(P_HOLD, wm, wg);
                        else m_grant = wg;
                    end
                    else if (m_grant == 2) go(P_LOST, lost_of(m_mode), 2);
                    else go(P_IDLE, 7, 0);
                end
                P_HOLD: begin
                    if (obs_s) go(P_BLK, 7, 1);
                    else if (man_s && m_grant == 2) go(P_HOLD, mm, 3);
                    else if (age >= H) go(P_RUN, m_mode, m_grant);
                end
                P_LOST: begin
                    if (obs_s) go(P_BLK, 7, 1);
                    else if (wv) go(P_RUN, wm, wg);
                    else if (m_mode == 7 || age >= LT) go(P_HALT, 7, 0);
                end
                P_HALT: begin
                    if (man_s || lin_s) go(P_IDLE, 7, 0);
                end
                default: begin
                    if (!obs_s) go(P_IDLE, 7, 0);
                end
            endcase
        end
        nonstop = (m_mode == 7) ? 0 : nonstop + 1;
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (model_on) begin
            chk("mode", int'(bus.mode_out), m_mode);
            chk("duty", int'(bus.duty), exp_duty());
            chk("grant", int'(bus.grant), m_grant);
            chk("lost", int'(bus.lost), (ph == P_LOST || ph == P_HALT) ? 1 : 0);
            chk("dir_left", int'(bus.dir_left), dl_tab[m_mode]);
            chk("dir_right", int'(bus.dir_right), dr_tab[m_mode]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mode"}, int'(bus.mode_out), 7);
        chk({tag, "_duty"}, int'(bus.duty), 0);
        chk({tag, "_dirl"}, int'(bus.dir_left), 0);
        chk({tag, "_dirr"}, int'(bus.dir_right), 0);
        chk({tag, "_grant"}, int'(bus.grant), 0);
        chk({tag, "_lost"}, int'(bus.lost), 0);
    endtask

    int duty_tab [10] = '{0, 256, 256, 512, 512, 768, 768, 1023, 1023, 1023};
    int last_chg;
    int prev_mode;

    initial begin
        bus.obs_stop   = 1'b0;
        bus.man_en     = 1'b0;
        bus.man_mode   = 3'b000;
        bus.line_valid = 1'b0;
        bus.line_mode  = 3'b000;
        tick();
        model_on = 1'b1;
        tick();
        tick();
        chk_reset("reset");
        chk("model_reset_pin", m_mode, 7);
        rst = 1'b0;

        // Line takes over and duty ramps to saturation.
        bus.line_valid = 1'b1;
        bus.line_mode  = 3'b110;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ramp_duty", int'(bus.duty), duty_tab[i]);
        end
        chk("ramp_mode", int'(bus.mode_out), 6);
        chk("ramp_grant", int'(bus.grant), 2);
        chk("model_duty_pin", exp_duty(), 1023);

        // Chatter on line_mode is absorbed by the dwell.
        last_chg  = -1;
        prev_mode = int'(bus.mode_out);
        for (int i = 0; i < 24; i++) begin
            bus.line_mode = (i % 2 == 0) ? 3'b100 : 3'b101;
            tick();
            if (int'(bus.mode_out) != prev_mode) begin
                if (last_chg >= 0) chk("hold_gap", int'((i - last_chg) >= H), 1);
                last_chg  = i;
                prev_mode = int'(bus.mode_out);
            end
            chk("chatter_dirl", int'(bus.dir_left), 1);
            chk("chatter_dirr", int'(bus.dir_right), 1);
        end

        // Line lost in TURN_R: recovery hard-right, then halt on timeout.
        bus.line_mode = 3'b101;
        repeat (12) tick();
        chk("pre_lost_mode", int'(bus.mode_out), 5);
        bus.line_valid = 1'b0;
        tick();
        chk("lost_mode", int'(bus.mode_out), 1);
        chk("lost_dirl", int'(bus.dir_left), 1);
        chk("lost_dirr", int'(bus.dir_right), 2);
        chk("lost_flag", int'(bus.lost), 1);
        repeat (19) tick();
        chk("lost_late_mode", int'(bus.mode_out), 1);
        tick();
        chk("halt_mode", int'(bus.mode_out), 7);
        chk("halt_duty", int'(bus.duty), 0);
        chk("halt_lost", int'(bus.lost), 1);
        chk("halt_grant", int'(bus.grant), 0);
        bus.line_valid = 1'b1;
        tick();
        chk("halt_idle_mode", int'(bus.mode_out), 7);
        chk("halt_idle_lost", int'(bus.lost), 0);
        tick();
        chk("halt_run_mode", int'(bus.mode_out), 5);
        chk("halt_run_grant", int'(bus.grant), 2);

        // Obstacle preempts a hold.
        bus.line_mode = 3'b100;
        tick();
        chk("hold_mode", int'(bus.mode_out), 4);
        bus.obs_stop = 1'b1;
        tick();
        chk("blk_mode", int'(bus.mode_out), 7);
        chk("blk_duty", int'(bus.duty), 0);
        chk("blk_grant", int'(bus.grant), 1);
        bus.obs_stop = 1'b0;
        tick();
        chk("blk_idle_grant", int'(bus.grant), 0);
        tick();
        chk("blk_run_mode", int'(bus.mode_out), 4);
        chk("blk_run_duty", int'(bus.duty), 0);
        tick();
        chk("blk_ramp_duty", int'(bus.duty), 256);

        // Manual override of the line, then obstacle.
        bus.man_en   = 1'b1;
        bus.man_mode = 3'b000;
        tick();
        chk("man_mode", int'(bus.mode_out), 0);
        chk("man_grant", int'(bus.grant), 3);
        chk("man_dirl", int'(bus.dir_left), 2);
        chk("man_dirr", int'(bus.dir_right), 1);
        bus.obs_stop = 1'b1;
        tick();
        chk("man_obs_grant", int'(bus.grant), 1);

        // Reset in the middle of LOST with duty at 768.
        bus.obs_stop  = 1'b0;
        bus.man_en    = 1'b0;
        bus.line_mode = 3'b100;
        tick();
        tick();
        chk("rl_run_mode", int'(bus.mode_out), 4);
        repeat (4) tick();
        bus.line_valid = 1'b0;
        tick();
        chk("rl_duty", int'(bus.duty), 768);
        chk("rl_lost", int'(bus.lost), 1);
        chk("rl_mode", int'(bus.mode_out), 0);
        rst = 1'b1;
        tick();
        chk_reset("midreset");
        rst = 1'b0;

        // Line returns on the very timeout cycle: RUN wins.
        bus.line_valid = 1'b1;
        bus.line_mode  = 3'b101;
        tick();
        bus.line_valid = 1'b0;
        tick();
        repeat (19) tick();
        bus.line_valid = 1'b1;
        tick();
        chk("ret_mode", int'(bus.mode_out), 5);
        chk("ret_grant", int'(bus.grant), 2);
        chk("ret_lost", int'(bus.lost), 0);

        // Obstacle on the hold-expiry cycle: BLOCKED wins.
        bus.line_mode = 3'b100;
        tick();
        repeat (3) tick();
        bus.obs_stop = 1'b1;
        tick();
        chk("exp_obs_grant", int'(bus.grant), 1);
        chk("exp_obs_mode", int'(bus.mode_out), 7);
        bus.obs_stop = 1'b0;

        // Randomized traffic; the model checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.line_valid = ~bus.line_valid;
            if ($urandom_range(0, 5) == 0) bus.line_mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) bus.man_en = ~bus.man_en;
            if ($urandom_range(0, 9) == 0) bus.man_mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 60) == 0) bus.obs_stop = 1'b1;
            else if ($urandom_range(0, 3) == 0) bus.obs_stop = 1'b0;
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end

        model_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/drive_arbiter.md
Name: drive_arbiter

Overview:
- Sequences the motor/PWM datapath.
- Arbitrates drive-mode requests from three sources: ultrasonic obstacle stop, line tracker, and manual override.
- Adds a mode-hold dwell against chatter, a lost-line recovery timeout, and a soft-start duty ramp.
- Sits between the sensor blocks and the motor block; outputs are the motor mode code, PWM duty and H-bridge direction bits.

Parameters:
- HOLD_CYCLES, 5_000_000: minimum cycles a newly granted mode is held (50 ms at 100 MHz).
- LOST_TIMEOUT, 100_000_000: cycles of recovery turning allowed while the line is lost before halting.
- RAMP_DIV, 100_000: cycles between duty ramp increments.
- RAMP_STEP, 8: duty increment per ramp tick.
- DUTY_MAX, 1023: duty saturation value (10-bit).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- obs_stop  in  1  obstacle too close; highest priority.
- man_en  in  1  manual override request.
- man_mode  in  3  manual mode code.
- line_valid  in  1  tracker sees the line.
- line_mode  in  3  tracker-requested mode code.
- mode_out  out  3  registered mode to the motor block.
- duty  out  10  registered PWM duty.
- dir_left  out  2  left H-bridge direction.
- dir_right  out  2  right H-bridge direction.
- grant  out  2  current owner: 00 none, 01 obstacle, 10 line, 11 manual.
- lost  out  1  high in LOST and HALT.

Behaviour:
- Mode codes: HARD_TURN_L=000, HARD_TURN_R=001, MAINTAIN=010, TURN_L=100, TURN_R=101, MIDDLE=110, STOP=111. Any other input code is treated as STOP.
- Priority: obs_stop > man_en > line_valid. All outputs are registered; an input change appears on the outputs 1 cycle later.
- Reset values: state IDLE, mode_out=111, duty=0, dir_left=dir_right=00, grant=00, lost=0; all counters cleared. Reset mid-operation aborts any hold, lost timing or ramp.
- IDLE: STOP, grant 00.
  - obs_stop → BLOCKED.
  - man_en, or line_valid → RUN (winner's mode latched).
- RUN: mode_out follows the winner's code.
  - When the latched mode changes: load hold counter with HOLD_CYCLES-1 → HOLD.
  - Line owner with line_valid=0 → LOST.
  - Manual owner drops man_en with no line → IDLE.
- HOLD: mode_out frozen; requests are ignored.
  - Counter reaches 0 → RUN next cycle, then re-evaluate.
  - obs_stop preempts immediately → BLOCKED.
  - man_en rising while the line owns the grant also preempts and starts a fresh HOLD with the manual mode.
- LOST: mode_out keeps the last mode, mapped as follows:
  - TURN_L/HARD_TURN_L → HARD_TURN_L.
  - TURN_R/HARD_TURN_R → HARD_TURN_R.
  - Anything else → STOP, then HALT next cycle.
  - Counter runs LOST_TIMEOUT cycles. line_valid returning → RUN. Expiry → HALT. obs_stop → BLOCKED. man_en → RUN with manual grant.
- HALT: STOP, duty 0, lost=1, grant 00. Leaves to IDLE only on man_en or line_valid.
- BLOCKED: STOP, duty forced 0 on the same clock edge, grant 01. obs_stop low → IDLE. Hold and lost counters are cleared.
- Duty:
  - mode_out=STOP: duty=0 and the ramp divider is cleared.
  - Otherwise, every RAMP_DIV cycles: duty = min(duty+RAMP_STEP, DUTY_MAX), computed 11-bit and saturated, never wrapping.
  - Switching between non-STOP modes does not reset duty.
- Direction:
  - STOP: 00/00.
  - HARD_TURN_L: left 10, right 01.
  - HARD_TURN_R: left 01, right 10.
  - All other modes: 01/01.
- Simultaneous events:
  - obs_stop in the same cycle as hold expiry or lost timeout → BLOCKED wins.
  - line_valid returning in the same cycle as LOST timeout → RUN wins.

Test Plan (HOLD_CYCLES=4, LOST_TIMEOUT=20, RAMP_DIV=2, RAMP_STEP=256, DUTY_MAX=1023):
- Reset, then line_valid=1, line_mode=110 → next cycle mode_out=110, grant=10; duty reads 0,256,512,768,1023 on successive ramp ticks, then stays at 1023.
- In RUN with mode 110, line_mode toggles 100 ↔ 101 every cycle → mode_out changes at most once per 4 cycles; dir stays 01/01.
- Line owner in mode 101, then line_valid=0 → mode_out=001, dir left 01 / right 10, lost=1. After 20 cycles → HALT with mode 111, duty 0. line_valid=1 → IDLE, then RUN.
- obs_stop=1 during HOLD with mode 100 → next cycle mode_out=111, duty=0, grant=01. obs_stop released → IDLE, then RUN; duty ramps from 0.
- Line owner, then man_en=1 with man_mode=000 → mode_out=000, grant=11, dir left 10 / right 01. Then obs_stop=1 → grant=01.
- rst asserted mid-LOST with duty 768 → next cycle all outputs equal their reset values; lost=0.
